// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM hazard inputs in, pipeline stall/flush controls out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1addr;
    logic [4:0]       id_rs2addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rdaddr;
    logic             ex_regwr;
    logic [1:0]       ex_wbsel;
    logic             ex_willjmp;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pc_redirect;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies hazard information, consumes controls
    modport master (
        output id_rs1addr, id_rs2addr, id_uses_rs1, id_uses_rs2,
        output ex_rdaddr, ex_regwr, ex_wbsel, ex_willjmp, mem_req, mem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
        input  if_id_flush, id_ex_flush, pc_redirect, mem_err, stall_cnt, flush_cnt
    );

    // Scheduler side
    modport slave (
        input  id_rs1addr, id_rs2addr, id_uses_rs1, id_uses_rs2,
        input  ex_rdaddr, ex_regwr, ex_wbsel, ex_willjmp, mem_req, mem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
        output if_id_flush, id_ex_flush, pc_redirect, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, redirect
// flushes and data-memory wait freezes, plus performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [1:0]  WB_MEM       = 2'b01,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int unsigned    FCNT_W    = 4;
    localparam int unsigned    TCNT_W    = 16;
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(MEM_TIMEOUT);
    localparam bit             MULTI_FLUSH = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_FLUSH   = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    state_t             eval_state;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

    logic               rs1_hit, rs2_hit, load_use, mem_busy;
    logic               pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c;
    logic               if_id_flush_c, id_ex_flush_c, pc_redirect_c;

    // Hazard detection terms
    assign rs1_hit  = hz.id_uses_rs1 && (hz.id_rs1addr == hz.ex_rdaddr);
    assign rs2_hit  = hz.id_uses_rs2 && (hz.id_rs2addr == hz.ex_rdaddr);
    assign load_use = hz.ex_regwr && (hz.ex_wbsel == WB_MEM) && (hz.ex_rdaddr != 5'd0)
                      && (rs1_hit || rs2_hit);
    assign mem_busy = hz.mem_req && !hz.mem_ready;

    // On the release cycle of a memory wait, decisions use the saved return state
    assign eval_state = (state_q == S_MEMWAIT) ? ret_q : state_q;

    // Next-state and same-cycle control outputs, highest priority first
    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        fcnt_d         = fcnt_q;
        tcnt_d         = tcnt_q;
        mem_err_d      = mem_err_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        pc_redirect_c  = 1'b0;

        if (rst) begin
            if (mem_busy) begin
                pc_stall_c     = 1'b1;
                if_id_stall_c  = 1'b1;
                id_ex_stall_c  = 1'b1;
                ex_mem_stall_c = 1'b1;
                state_d        = S_MEMWAIT;
                if (state_q != S_MEMWAIT) begin
                    ret_d = state_q;
                end
                if (tcnt_q != TCNT_MAX) begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
                if (tcnt_d == TCNT_MAX) begin
                    mem_err_d = 1'b1;
                end
            end else begin
                tcnt_d = '0;
                if (eval_state == S_RUN && hz.ex_willjmp) begin
                    pc_redirect_c = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FCNT_INIT;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (eval_state == S_FLUSH) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (fcnt_q <= FCNT_W'(1)) begin
                        state_d = S_RUN;
                        fcnt_d  = '0;
                    end else begin
                        state_d = S_FLUSH;
                        fcnt_d  = fcnt_q - FCNT_W'(1);
                    end
                end else begin
                    state_d = S_RUN;
                    if (load_use) begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        id_ex_stall_c = 1'b1;
                    end
                end
            end
        end
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            ret_q       <= S_RUN;
            fcnt_q      <= '0;
            tcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            fcnt_q    <= fcnt_d;
            tcnt_q    <= tcnt_d;
            mem_err_q <= mem_err_d;
            if (pc_stall_c) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (pc_redirect_c) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.if_id_stall  = if_id_stall_c;
    assign hz.id_ex_stall  = id_ex_stall_c;
    assign hz.ex_mem_stall = ex_mem_stall_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_flush  = id_ex_flush_c;
    assign hz.pc_redirect  = pc_redirect_c;
    assign hz.mem_err      = mem_err_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It drives the stall inputs of the PC, IF/ID, ID/EX and EX/MEM registers and the flush inputs of IF/ID and ID/EX. It sequences three hazard types:
- load-use bubbles
- taken-branch/jump redirect flushes
- multi-cycle data-memory waits

It also keeps stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
FLUSH_CYCLES, 1, cycles IF/ID and ID/EX flush is held after a redirect (1..15)
WB_MEM, 2'b01, wbsel encoding meaning "writeback from data memory" (load)
MEM_TIMEOUT, 255, MEMWAIT cycles before mem_err sets (1..65535)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs1addr  in  5  rs1 of instruction in ID
id_rs2addr  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rdaddr  in  5  rd of instruction in EX
ex_regwr  in  1  EX instruction writes rd
ex_wbsel  in  2  EX writeback select
ex_willjmp  in  1  EX resolved a taken branch or jump
mem_req  in  1  MEM-stage access in progress
mem_ready  in  1  data memory completes access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
id_ex_stall  out  1  ID/EX stall (ID/EX inserts bubble)
ex_mem_stall  out  1  hold EX/MEM
if_id_flush  out  1  squash IF/ID
id_ex_flush  out  1  squash ID/EX
pc_redirect  out  1  PC loads jump target
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with pc_stall=1
flush_cnt  out  CNT_W  redirect events accepted

Behaviour:
Reset (rst=0, asynchronous):
- state=RUN; flush and timeout counters = 0.
- All outputs 0, including mem_err and both performance counters.

Hazard terms (combinational):
- load_use = ex_regwr & (ex_wbsel==WB_MEM) & (ex_rdaddr!=0) & ((id_uses_rs1 & id_rs1addr==ex_rdaddr) | (id_uses_rs2 & id_rs2addr==ex_rdaddr))
- mem_busy = mem_req & !mem_ready

Control outputs are combinational from state and inputs, same cycle. Priority per cycle:
1. mem_busy → freeze: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall all 1; no flush; pc_redirect=0. In the FLUSH state this also holds flushes at 0 and does not decrement the flush counter.
2. RUN & ex_willjmp → pc_redirect=1, if_id_flush=1, id_ex_flush=1, all stalls 0. flush_cnt+1. If FLUSH_CYCLES>1: go to FLUSH with fcnt=FLUSH_CYCLES-1.
3. FLUSH (not frozen) → if_id_flush=1, id_ex_flush=1. fcnt-1; at fcnt==1 go to RUN. In FLUSH, ex_willjmp and load_use are ignored because the instructions are squashed.
4. RUN & load_use → pc_stall, if_id_stall, id_ex_stall =1; ex_mem_stall=0. Exactly one bubble; the hazard clears next cycle once the load is in MEM.
5. Otherwise all outputs 0.

State machine RUN / FLUSH / MEMWAIT:
- Any state with mem_busy: go to MEMWAIT and save the return state (RUN or FLUSH).
- MEMWAIT: tcnt increments each mem_busy cycle. At tcnt==MEM_TIMEOUT, mem_err <= 1 (sticky until reset); stalls continue.
- MEMWAIT with mem_ready=1: freeze drops that cycle. Priority 2–4 is evaluated against the saved return state, and the state moves to that return state (or FLUSH, if a redirect occurs). tcnt clears.
- A redirect while frozen is deferred. ex_willjmp is held by the frozen EX stage and is accepted on the release cycle.

Counters:
- stall_cnt increments on every cycle with pc_stall=1; flush_cnt increments on each accepted redirect.
- Both wrap modulo 2^CNT_W with no saturation.

Simultaneous events:
- Redirect and load_use together → redirect wins; no stall, and stall_cnt does not increment.
- mem_busy and redirect together → freeze wins; flush_cnt does not increment until the redirect is accepted.

Reset mid-MEMWAIT or mid-FLUSH → immediate return to RUN with all outputs 0.

Test Plan:
- Load-use: ex_regwr=1, ex_wbsel=01, ex_rdaddr=5, id_uses_rs2=1, id_rs2addr=5 → pc_stall, if_id_stall and id_ex_stall =1 for exactly 1 cycle; stall_cnt=1. Repeat with ex_rdaddr=0 → no stall.
- Redirect with FLUSH_CYCLES=3: ex_willjmp pulse → pc_redirect=1 for 1 cycle; both flushes =1 for 3 consecutive cycles; flush_cnt=1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then mem_ready=1 → all four stalls =1 for 4 cycles, 0 on the ready cycle; stall_cnt=4.
- Timeout with MEM_TIMEOUT=8: hold mem_busy for 10 cycles → mem_err rises after 8 MEMWAIT cycles and stays 1 after mem_ready; cleared only by rst=0.
- Priority: ex_willjmp with load_use together → redirect and flush, no stall. ex_willjmp during mem_busy → redirect deferred to the mem_ready cycle.
- Asynchronous reset: assert rst=0 mid-FLUSH (between clock edges) → all outputs 0 immediately; after release, state is RUN and the counters read 0.
